// File: rtl/o_stream_packer.sv
// Packs two byte streams (row/column) into 4-byte words, tags them by source and
// queues them through a shared show-ahead output FIFO with round-robin arbitration.
module o_stream_packer #(
  parameter int unsigned W_DATA = 8,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [W_DATA-1:0]         i_row_data,
  input  logic                      i_row_valid,
  input  logic [W_DATA-1:0]         i_col_data,
  input  logic                      i_col_valid,
  input  logic                      i_flush,
  input  logic                      i_ready,
  output logic [4*W_DATA-1:0]       o_data,
  output logic                      o_tag,
  output logic [1:0]                o_bytes,
  output logic                      o_valid,
  output logic [$clog2(DEPTH):0]    o_count,
  output logic                      o_overflow
);

  localparam int unsigned W_WORD = 4 * W_DATA;
  localparam int unsigned AW     = $clog2(DEPTH);
  localparam int unsigned W_ENT  = W_WORD + 3;

  // Per-stream state, index 0 = row, 1 = column
  logic [1:0]        cnt_q       [2];
  logic [1:0]        cnt_d       [2];
  logic [W_WORD-1:0] pack_q      [2];
  logic [W_WORD-1:0] pack_d      [2];
  logic              pend_v_q    [2];
  logic              pend_v_d    [2];
  logic [W_WORD-1:0] pend_data_q [2];
  logic [W_WORD-1:0] pend_data_d [2];
  logic [1:0]        pend_bytes_q[2];
  logic [1:0]        pend_bytes_d[2];
  logic              prio_q, prio_d;
  logic              ovf_q, ovf_d;

  logic [W_ENT-1:0]  mem_q [DEPTH];
  logic [AW:0]       wr_q, rd_q;
  logic [AW:0]       count;
  logic              full, empty, push, pop, grant, both;
  logic [W_ENT-1:0]  head;

  logic [W_DATA-1:0] in_data  [2];
  logic              in_valid [2];
  logic [W_WORD-1:0] word;
  logic [2:0]        fill;
  logic              close;

  assign in_data[0]  = i_row_data;
  assign in_data[1]  = i_col_data;
  assign in_valid[0] = i_row_valid;
  assign in_valid[1] = i_col_valid;

  // FIFO status and arbitration
  assign count = wr_q - rd_q;
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign pop   = !empty && i_ready;
  assign both  = pend_v_q[0] && pend_v_q[1];
  assign grant = both ? prio_q : pend_v_q[1];
  assign push  = (pend_v_q[0] || pend_v_q[1]) && (!full || pop);

  always_comb begin
    prio_d = prio_q;
    ovf_d  = ovf_q;
    word   = '0;
    fill   = '0;
    close  = 1'b0;
    if (push && both) prio_d = !prio_q;
    for (int s = 0; s < 2; s++) begin
      cnt_d[s]        = cnt_q[s];
      pack_d[s]       = pack_q[s];
      pend_v_d[s]     = pend_v_q[s];
      pend_data_d[s]  = pend_data_q[s];
      pend_bytes_d[s] = pend_bytes_q[s];

      word = pack_q[s];
      fill = {1'b0, cnt_q[s]};
      if (in_valid[s]) begin
        for (int k = 0; k < 4; k++) begin
          if (cnt_q[s] == 2'(k)) word[k*W_DATA +: W_DATA] = in_data[s];
        end
        fill = fill + 3'd1;
      end
      close = (fill == 3'd4) || (i_flush && (fill != 3'd0));

      if (push && (grant == 1'(s))) pend_v_d[s] = 1'b0;

      // Pack register is cleared on close so a short word has zero upper bytes
      if (close) begin
        cnt_d[s]  = '0;
        pack_d[s] = '0;
        if (pend_v_d[s]) begin
          ovf_d = 1'b1;
        end else begin
          pend_v_d[s]     = 1'b1;
          pend_data_d[s]  = word;
          pend_bytes_d[s] = 2'(fill - 3'd1);
        end
      end else begin
        cnt_d[s]  = fill[1:0];
        pack_d[s] = word;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int s = 0; s < 2; s++) begin
        cnt_q[s]        <= '0;
        pack_q[s]       <= '0;
        pend_v_q[s]     <= 1'b0;
        pend_data_q[s]  <= '0;
        pend_bytes_q[s] <= '0;
      end
      prio_q <= 1'b0;
      ovf_q  <= 1'b0;
      wr_q   <= '0;
      rd_q   <= '0;
    end else begin
      for (int s = 0; s < 2; s++) begin
        cnt_q[s]        <= cnt_d[s];
        pack_q[s]       <= pack_d[s];
        pend_v_q[s]     <= pend_v_d[s];
        pend_data_q[s]  <= pend_data_d[s];
        pend_bytes_q[s] <= pend_bytes_d[s];
      end
      prio_q <= prio_d;
      ovf_q  <= ovf_d;
      if (push) wr_q <= wr_q + (AW+1)'(1);
      if (pop)  rd_q <= rd_q + (AW+1)'(1);
    end
  end

  // FIFO storage needs no reset; reads are masked while empty
  always_ff @(posedge i_clk) begin
    if (push) mem_q[wr_q[AW-1:0]] <= {pend_bytes_q[grant], grant, pend_data_q[grant]};
  end

  assign head       = mem_q[rd_q[AW-1:0]];
  assign o_valid    = !empty;
  assign o_data     = empty ? '0   : head[W_WORD-1:0];
  assign o_tag      = empty ? 1'b0 : head[W_WORD];
  assign o_bytes    = empty ? 2'b0 : head[W_WORD+2:W_WORD+1];
  assign o_count    = count;
  assign o_overflow = ovf_q;

endmodule

// File: tb/tb_o_stream_packer.sv
// Directed bench for o_stream_packer: packing, flush, arbitration, overflow, reset.
module tb_o_stream_packer;

  localparam int unsigned W_DATA = 8;
  localparam int unsigned DEPTH  = 4;

  logic                   i_clk = 1'b0;
  logic                   i_rst_n;
  logic [W_DATA-1:0]      i_row_data, i_col_data;
  logic                   i_row_valid, i_col_valid, i_flush, i_ready;
  logic [4*W_DATA-1:0]    o_data;
  logic                   o_tag, o_valid, o_overflow;
  logic [1:0]             o_bytes;
  logic [$clog2(DEPTH):0] o_count;

  int checks = 0;
  int errors = 0;

  o_stream_packer #(.W_DATA(W_DATA), .DEPTH(DEPTH)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_row_data(i_row_data), .i_row_valid(i_row_valid),
    .i_col_data(i_col_data), .i_col_valid(i_col_valid),
    .i_flush(i_flush), .i_ready(i_ready),
    .o_data(o_data), .o_tag(o_tag), .o_bytes(o_bytes), .o_valid(o_valid),
    .o_count(o_count), .o_overflow(o_overflow)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply inputs for one edge, then sample 1ns after it with inputs idle
  task automatic step(input logic rv, input logic [7:0] rd, input logic cv,
                      input logic [7:0] cd, input logic fl);
    i_row_valid = rv; i_row_data = rd;
    i_col_valid = cv; i_col_data = cd;
    i_flush     = fl;
    @(posedge i_clk); #1;
    i_row_valid = 1'b0; i_col_valid = 1'b0; i_flush = 1'b0;
    i_row_data  = '0;   i_col_data  = '0;
  endtask

  task automatic idle();
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
  endtask

  logic [31:0] exp_w;

  initial begin
    i_rst_n = 1'b0; i_ready = 1'b1;
    i_row_valid = 1'b0; i_col_valid = 1'b0; i_flush = 1'b0;
    i_row_data = '0; i_col_data = '0;
    #12;
    chk("rst_valid", 64'(o_valid), 64'd0);
    chk("rst_count", 64'(o_count), 64'd0);
    chk("rst_data",  64'(o_data),  64'd0);
    chk("rst_tag",   64'(o_tag),   64'd0);
    chk("rst_bytes", 64'(o_bytes), 64'd0);
    chk("rst_ovf",   64'(o_overflow), 64'd0);
    @(posedge i_clk); #1; i_rst_n = 1'b1;

    // Single row word and its latency
    step(1'b1, 8'h11, 1'b0, 8'h00, 1'b0);
    step(1'b1, 8'h22, 1'b0, 8'h00, 1'b0);
    step(1'b1, 8'h33, 1'b0, 8'h00, 1'b0);
    step(1'b1, 8'h44, 1'b0, 8'h00, 1'b0);
    chk("lat_e0_valid", 64'(o_valid), 64'd0);
    idle();
    chk("row_valid", 64'(o_valid), 64'd1);
    chk("row_data",  64'(o_data),  64'h44332211);
    chk("row_tag",   64'(o_tag),   64'd0);
    chk("row_bytes", 64'(o_bytes), 64'd3);
    idle();
    chk("row_drain", 64'(o_count), 64'd0);

    // Simultaneous completion: row first, then column first on repeat
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 4; i++)
        step(1'b1, 8'(8*r + i + 1), 1'b1, 8'(8*r + i + 5), 1'b0);
      idle();
      chk("arb_cnt1", 64'(o_count), 64'd1);
      chk("arb_tag1", 64'(o_tag), (r == 0) ? 64'd0 : 64'd1);
      chk("arb_dat1", 64'(o_data), (r == 0) ? 64'h04030201 : 64'h10_0f_0e_0d);
      idle();
      chk("arb_tag2", 64'(o_tag), (r == 0) ? 64'd1 : 64'd0);
      chk("arb_dat2", 64'(o_data), (r == 0) ? 64'h08070605 : 64'h0c_0b_0a_09);
      idle();
      chk("arb_drain", 64'(o_valid), 64'd0);
    end

    // Partial column word closed by flush
    step(1'b0, 8'h00, 1'b1, 8'hAA, 1'b0);
    step(1'b0, 8'h00, 1'b1, 8'hBB, 1'b0);
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    idle();
    chk("fl_count", 64'(o_count), 64'd1);
    chk("fl_data",  64'(o_data),  64'h0000BBAA);
    chk("fl_tag",   64'(o_tag),   64'd1);
    chk("fl_bytes", 64'(o_bytes), 64'd1);
    idle();
    chk("fl_only_one", 64'(o_valid), 64'd0);

    // Flush together with the 4th byte yields one full word only
    step(1'b1, 8'h01, 1'b0, 8'h00, 1'b0);
    step(1'b1, 8'h02, 1'b0, 8'h00, 1'b0);
    step(1'b1, 8'h03, 1'b0, 8'h00, 1'b0);
    step(1'b1, 8'h04, 1'b0, 8'h00, 1'b1);
    idle();
    chk("fl4_data",  64'(o_data),  64'h04030201);
    chk("fl4_bytes", 64'(o_bytes), 64'd3);
    idle();
    chk("fl4_single", 64'(o_valid), 64'd0);

    // Backpressure: fill FIFO and pending, drop the sixth word
    i_ready = 1'b0;
    for (int i = 0; i < 24; i++) step(1'b1, 8'(i + 1), 1'b0, 8'h00, 1'b0);
    idle(); idle();
    chk("bp_count", 64'(o_count), 64'(DEPTH));
    chk("bp_ovf",   64'(o_overflow), 64'd1);
    i_ready = 1'b1;
    for (int n = 0; n < 5; n++) begin
      exp_w = {8'(4*n + 4), 8'(4*n + 3), 8'(4*n + 2), 8'(4*n + 1)};
      chk("bp_valid", 64'(o_valid), 64'd1);
      chk("bp_data",  64'(o_data),  64'(exp_w));
      idle();
    end
    chk("bp_empty", 64'(o_valid), 64'd0);
    chk("bp_ovf_sticky", 64'(o_overflow), 64'd1);

    // Reset mid-operation discards queued and partial words
    i_ready = 1'b0;
    for (int i = 0; i < 14; i++) step(1'b1, 8'(i + 32), 1'b0, 8'h00, 1'b0);
    chk("mr_count", 64'(o_count), 64'd3);
    #2 i_rst_n = 1'b0;
    #1;
    chk("mr_valid", 64'(o_valid), 64'd0);
    chk("mr_count0", 64'(o_count), 64'd0);
    chk("mr_data",  64'(o_data),  64'd0);
    chk("mr_ovf",   64'(o_overflow), 64'd0);
    @(posedge i_clk); #1; i_rst_n = 1'b1; i_ready = 1'b1;
    step(1'b1, 8'h01, 1'b0, 8'h00, 1'b0);
    step(1'b1, 8'h02, 1'b0, 8'h00, 1'b0);
    step(1'b1, 8'h03, 1'b0, 8'h00, 1'b0);
    step(1'b1, 8'h04, 1'b0, 8'h00, 1'b0);
    idle();
    chk("mr_post_data", 64'(o_data), 64'h04030201);
    chk("mr_post_tag",  64'(o_tag),  64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
